alu_imm_sequencer: RTL and testbench
====================================

ALU_IMM_SEQUENCER -- requirements
Module: alu_imm_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, bus and immediate-extended width.
REQ-002 Parameter ADDR_W, default 6, register address width.
REQ-003 Parameter IMM_W, default 6, raw immediate width; SHALL satisfy 1 <= IMM_W <= DATA_W.
REQ-004 Parameter OP_W, default 4, opcode / ALU control width.
REQ-005 clock  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 FSM_start  input  1  request; sampled only in IDLE.
REQ-008 opcode  input  OP_W  ALU operation, captured at accept.
REQ-009 param1  input  ADDR_W  source register address, captured at accept.
REQ-010 param2  input  ADDR_W  destination register address, captured at accept (used only with ALU_IMM_DEST_EN).
REQ-011 immediate  input  IMM_W  raw immediate, captured at accept.
REQ-012 imm_signed  input  1  1 = sign-extend immediate, 0 = zero-extend; captured at accept.
REQ-013 FSM_bus_output  output  DATA_W  extended immediate when driving, high-impedance otherwise.
REQ-014 bus_register_out_en, bus_register_input_en, latched_bus1_en, latched_bus2_en, alu_bus_out_en  output  1 each  datapath strobes.
REQ-015 register_addr  output  ADDR_W  register file address.
REQ-016 alu_control  output  OP_W  ALU operation select.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.

Function
REQ-019 States SHALL be IDLE, RD_SRC, LATCH_A, DRIVE_IMM, LATCH_B, ALU_OUT, WRITE, DONE; outputs decoded from the registered state (Moore).
REQ-020 IDLE -> RD_SRC when FSM_start == 1 at a rising edge; opcode, param1, param2, immediate, imm_signed registered on that same edge; otherwise stay IDLE.
REQ-021 All non-IDLE states SHALL advance unconditionally in listed order; DONE -> IDLE.
REQ-022 RD_SRC: register_addr = src, bus_register_out_en = 1.
REQ-023 LATCH_A: register_addr = src, bus_register_out_en = 1, latched_bus1_en = 1, alu_control = opcode.
REQ-024 DRIVE_IMM: bus_register_out_en = 0, FSM_bus_output driven with extended immediate.
REQ-025 LATCH_B: FSM_bus_output still driven, latched_bus2_en = 1.
REQ-026 ALU_OUT: FSM_bus_output high-Z, alu_bus_out_en = 1, register_addr = dst.
REQ-027 WRITE: alu_bus_out_en = 1, bus_register_input_en = 1, register_addr = dst.
REQ-028 DONE: done = 1, all other strobes 0.
REQ-029 alu_control SHALL hold captured opcode from LATCH_A through WRITE; 0 elsewhere.
REQ-030 Strobes not listed for a state SHALL be 0; register_addr 0 in IDLE and DONE.
REQ-031 Extension: bits [IMM_W-1:0] = immediate; upper DATA_W-IMM_W bits = immediate[IMM_W-1] if imm_signed else 0; IMM_W == DATA_W passes through unchanged.
REQ-032 Immediate drive and bus_register_out_en SHALL never be active in the same cycle.
REQ-033 Latency: done high exactly 7 cycles after the accepting edge; a new FSM_start accepted at the edge ending DONE+1 (IDLE) at earliest, i.e. 8-cycle throughput.
REQ-034 FSM_start and input changes while busy SHALL be ignored; captured values remain stable.
REQ-035 FSM_start held continuously SHALL start back-to-back operations, one per 8 cycles.

Reset
REQ-036 reset == 0 at a rising edge SHALL force IDLE regardless of current state, including mid-operation.
REQ-037 From the cycle after reset: all strobes 0, done 0, busy 0, register_addr 0, alu_control 0, FSM_bus_output high-Z, captured registers 0; no done pulse for an aborted operation.
REQ-038 FSM_start sampled during reset SHALL be ignored.

Configuration
REQ-039 Macro ALU_IMM_DEST_EN defined: dst = captured param2 (three-address form).
REQ-040 ALU_IMM_DEST_EN undefined: dst = captured param1 (write back to source), param2 port present but ignored, no param2 capture register.

Verification
REQ-041 Defaults, imm=6'b111011, imm_signed=1 -> FSM_bus_output = 16'hFFFB during DRIVE_IMM and LATCH_B only.
REQ-042 Same imm, imm_signed=0 -> 16'h003B; IMM_W=DATA_W=16, imm=16'h8001 -> 16'h8001 either mode.
REQ-043 Start, param1=6'd5, param2=6'd9, opcode=4'h3 -> register_addr 5 in RD_SRC/LATCH_A, 9 in ALU_OUT/WRITE with macro (5 without); done high 7 cycles after accept, one cycle wide.
REQ-044 Pulse FSM_start and change opcode/immediate during cycles 2-6 -> ignored, original values used, no restart.
REQ-045 reset low during LATCH_B -> next cycle IDLE, all strobes 0, bus high-Z, no done; operation accepted normally after release.
REQ-046 FSM_start held high 24 cycles -> exactly 3 done pulses, 8 cycles apart; bus_register_out_en and immediate drive never overlap.

Source files
------------

// File: rtl/alu_imm_sequencer_if.sv
// Handshake and datapath-strobe bundle between a controller and alu_imm_sequencer.
interface alu_imm_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int IMM_W  = 6,
  parameter int OP_W   = 4
);
  logic              FSM_start;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] param1;
  logic [ADDR_W-1:0] param2;
  logic [IMM_W-1:0]  immediate;
  logic              imm_signed;
  logic              bus_register_out_en;
  logic              bus_register_input_en;
  logic              latched_bus1_en;
  logic              latched_bus2_en;
  logic              alu_bus_out_en;
  logic [ADDR_W-1:0] register_addr;
  logic [OP_W-1:0]   alu_control;
  logic              busy;
  logic              done;

  modport master (
    output FSM_start, opcode, param1, param2, immediate, imm_signed,
    input  bus_register_out_en, bus_register_input_en, latched_bus1_en,
           latched_bus2_en, alu_bus_out_en, register_addr, alu_control, busy, done
  );

  modport slave (
    input  FSM_start, opcode, param1, param2, immediate, imm_signed,
    output bus_register_out_en, bus_register_input_en, latched_bus1_en,
           latched_bus2_en, alu_bus_out_en, register_addr, alu_control, busy, done
  );
endinterface

// File: rtl/alu_imm_sequencer.sv
// Eight-state sequencer for "rd = rs OP ext(imm)": reads rs, drives the extended immediate, writes the ALU result.
// Define ALU_IMM_DEST_EN for three-address form (destination = param2); otherwise the result goes back to param1.
module alu_imm_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int IMM_W  = 6,
  parameter int OP_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  alu_imm_sequencer_if.slave io,
  output logic [DATA_W-1:0] FSM_bus_output
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_SRC    = 3'd1,
    S_LATCH_A   = 3'd2,
    S_DRIVE_IMM = 3'd3,
    S_LATCH_B   = 3'd4,
    S_ALU_OUT   = 3'd5,
    S_WRITE     = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm, input logic sgn);
    logic [DATA_W-1:0] r;
    r = {DATA_W{sgn & imm[IMM_W-1]}};
    r[IMM_W-1:0] = imm;
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              accept_s;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_s;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic              imm_signed_q, imm_signed_d;

  logic              reg_out_en_q, reg_out_en_d;
  logic              reg_in_en_q, reg_in_en_d;
  logic              latch1_q, latch1_d;
  logic              latch2_q, latch2_d;
  logic              alu_out_q, alu_out_d;
  logic              drive_q, drive_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] register_addr_q, register_addr_d;
  logic [OP_W-1:0]   alu_control_q, alu_control_d;

  // Next-state: only IDLE waits on a request, every other state steps forward.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (io.FSM_start) begin
          state_d  = S_RD_SRC;
          accept_s = 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RD_SRC:    state_d = S_LATCH_A;
      S_LATCH_A:   state_d = S_DRIVE_IMM;
      S_DRIVE_IMM: state_d = S_LATCH_B;
      S_LATCH_B:   state_d = S_ALU_OUT;
      S_ALU_OUT:   state_d = S_WRITE;
      S_WRITE:     state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Operand capture: inputs are frozen at the accepting edge and ignored while busy.
  always_comb begin
    if (accept_s) begin
      opcode_d     = io.opcode;
      src_d        = io.param1;
      imm_d        = io.immediate;
      imm_signed_d = io.imm_signed;
    end else begin
      opcode_d     = opcode_q;
      src_d        = src_q;
      imm_d        = imm_q;
      imm_signed_d = imm_signed_q;
    end
  end

`ifdef ALU_IMM_DEST_EN
  logic [ADDR_W-1:0] dst_q, dst_d;

  // Destination capture for the three-address form.
  always_comb begin
    if (accept_s) begin
      dst_d = io.param2;
    end else begin
      dst_d = dst_q;
    end
  end

  // Destination register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      dst_q <= {ADDR_W{1'b0}};
    end else begin
      dst_q <= dst_d;
    end
  end

  assign dst_s = dst_d;
`else
  logic unused_param2;
  assign unused_param2 = ^io.param2;
  assign dst_s         = src_d;
`endif

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    reg_out_en_d    = 1'b0;
    reg_in_en_d     = 1'b0;
    latch1_d        = 1'b0;
    latch2_d        = 1'b0;
    alu_out_d       = 1'b0;
    drive_d         = 1'b0;
    done_d          = 1'b0;
    busy_d          = (state_d != S_IDLE);
    register_addr_d = {ADDR_W{1'b0}};
    alu_control_d   = {OP_W{1'b0}};
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_RD_SRC: begin
        reg_out_en_d    = 1'b1;
        register_addr_d = src_d;
      end
      S_LATCH_A: begin
        reg_out_en_d    = 1'b1;
        latch1_d        = 1'b1;
        register_addr_d = src_d;
        alu_control_d   = opcode_d;
      end
      S_DRIVE_IMM: begin
        drive_d       = 1'b1;
        alu_control_d = opcode_d;
      end
      S_LATCH_B: begin
        drive_d       = 1'b1;
        latch2_d      = 1'b1;
        alu_control_d = opcode_d;
      end
      S_ALU_OUT: begin
        alu_out_d       = 1'b1;
        register_addr_d = dst_s;
        alu_control_d   = opcode_d;
      end
      S_WRITE: begin
        alu_out_d       = 1'b1;
        reg_in_en_d     = 1'b1;
        register_addr_d = dst_s;
        alu_control_d   = opcode_d;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, captured operands and output registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      opcode_q        <= {OP_W{1'b0}};
      src_q           <= {ADDR_W{1'b0}};
      imm_q           <= {IMM_W{1'b0}};
      imm_signed_q    <= 1'b0;
      reg_out_en_q    <= 1'b0;
      reg_in_en_q     <= 1'b0;
      latch1_q        <= 1'b0;
      latch2_q        <= 1'b0;
      alu_out_q       <= 1'b0;
      drive_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      register_addr_q <= {ADDR_W{1'b0}};
      alu_control_q   <= {OP_W{1'b0}};
    end else begin
      state_q         <= state_d;
      opcode_q        <= opcode_d;
      src_q           <= src_d;
      imm_q           <= imm_d;
      imm_signed_q    <= imm_signed_d;
      reg_out_en_q    <= reg_out_en_d;
      reg_in_en_q     <= reg_in_en_d;
      latch1_q        <= latch1_d;
      latch2_q        <= latch2_d;
      alu_out_q       <= alu_out_d;
      drive_q         <= drive_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      register_addr_q <= register_addr_d;
      alu_control_q   <= alu_control_d;
    end
  end

  assign FSM_bus_output           = drive_q ? extend_imm(imm_q, imm_signed_q) : {DATA_W{1'bz}};
  assign io.bus_register_out_en   = reg_out_en_q;
  assign io.bus_register_input_en = reg_in_en_q;
  assign io.latched_bus1_en       = latch1_q;
  assign io.latched_bus2_en       = latch2_q;
  assign io.alu_bus_out_en        = alu_out_q;
  assign io.register_addr         = register_addr_q;
  assign io.alu_control           = alu_control_q;
  assign io.busy                  = busy_q;
  assign io.done                  = done_q;

endmodule

// File: tb/tb_alu_imm_sequencer.sv
// Random + directed bench for alu_imm_sequencer against a cycle-count model of one operation.
module tb_alu_imm_sequencer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int IMM_W  = 6;
  localparam int OP_W   = 4;
`ifdef ALU_IMM_DEST_EN
  localparam int DST_LIT = 9;
`else
  localparam int DST_LIT = 5;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alu_imm_sequencer_if #(.ADDR_W(ADDR_W), .IMM_W(IMM_W), .OP_W(OP_W)) ifc ();
  wire [DATA_W-1:0] bus;
  alu_imm_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W), .OP_W(OP_W)) dut (
    .clock(clock), .reset(reset), .io(ifc), .FSM_bus_output(bus));

  alu_imm_sequencer_if #(.ADDR_W(6), .IMM_W(16), .OP_W(4)) ifc_w ();
  wire [15:0] bus_w;
  alu_imm_sequencer #(.DATA_W(16), .ADDR_W(6), .IMM_W(16), .OP_W(4)) dut_w (
    .clock(clock), .reset(reset), .io(ifc_w), .FSM_bus_output(bus_w));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic view of immediate extension: negative immediates gain 2^dw - 2^iw.
  function automatic int unsigned ext_model(input int unsigned imm, input bit sgn, input int iw, input int dw);
    if (sgn && imm >= (32'd1 << (iw - 1))) return imm + ((32'd1 << dw) - (32'd1 << iw));
    return imm;
  endfunction

  // Model: phase = cycles since the accepting edge (0 = idle, 7 = done cycle).
  int          phase_m = 0;
  int unsigned op_m = 0, src_m = 0, dst_m = 0, imm_m = 0;
  bit          sgn_m = 1'b0;

  always @(posedge clock) begin
    if (!reset) begin
      phase_m <= 0; op_m <= 0; src_m <= 0; dst_m <= 0; imm_m <= 0; sgn_m <= 1'b0;
    end else if (phase_m == 0) begin
      if (ifc.FSM_start) begin
        phase_m <= 1;
        op_m    <= ifc.opcode;
        src_m   <= ifc.param1;
`ifdef ALU_IMM_DEST_EN
        dst_m   <= ifc.param2;
`else
        dst_m   <= ifc.param1;
`endif
        imm_m   <= ifc.immediate;
        sgn_m   <= ifc.imm_signed;
      end
    end else begin
      phase_m <= (phase_m == 7) ? 0 : phase_m + 1;
    end
  end

  logic [6:0]  exp_strb, act_strb;
  int unsigned exp_addr, exp_op;

  always @(negedge clock) begin
    if (cmp_en) begin
      exp_strb = {phase_m != 0, phase_m == 7, phase_m inside {1, 2}, phase_m == 6,
                  phase_m == 2, phase_m == 4, phase_m inside {5, 6}};
      act_strb = {ifc.busy, ifc.done, ifc.bus_register_out_en, ifc.bus_register_input_en,
                  ifc.latched_bus1_en, ifc.latched_bus2_en, ifc.alu_bus_out_en};
      exp_addr = (phase_m inside {1, 2}) ? src_m : ((phase_m inside {5, 6}) ? dst_m : 0);
      exp_op   = (phase_m >= 2 && phase_m <= 6) ? op_m : 0;
      check("strobes", act_strb, exp_strb);
      check("register_addr", ifc.register_addr, exp_addr);
      check("alu_control", ifc.alu_control, exp_op);
      if (phase_m inside {3, 4})
        check("bus_drive", bus, ext_model(imm_m, sgn_m, IMM_W, DATA_W));
      else
        check("bus_idle", ((bus === {DATA_W{1'bz}}) || (bus == {DATA_W{1'b0}})) ? 1 : 0, 1);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (phase_m != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", (phase_m == 0) ? 1 : 0, 1);
  endtask

  // One operation with fixed operands, with garbage requests thrown at it while busy.
  task automatic run_directed(input logic sgn, input logic [15:0] exp_bus);
    ifc.FSM_start = 1'b1; ifc.opcode = 4'h3; ifc.param1 = 6'd5; ifc.param2 = 6'd9;
    ifc.immediate = 6'b111011; ifc.imm_signed = sgn;
    @(posedge clock);
    @(negedge clock);
    for (int k = 1; k <= 8; k++) begin
      if (k >= 2 && k <= 5) begin
        ifc.FSM_start = 1'b1; ifc.opcode = 4'hF;
        ifc.immediate = 6'($urandom); ifc.param1 = 6'($urandom); ifc.imm_signed = ~sgn;
      end else begin
        ifc.FSM_start = 1'b0;
      end
      check("lit_done", ifc.done, (k == 7) ? 1 : 0);
      if (k == 1 || k == 2) check("lit_src", ifc.register_addr, 5);
      if (k == 3 || k == 4) check("lit_imm", bus, exp_bus);
      if (k == 5 || k == 6) check("lit_dst", ifc.register_addr, DST_LIT);
      if (k == 2) check("lit_op", ifc.alu_control, 3);
      @(negedge clock);
    end
  endtask

  initial begin
    int dones, last, gap_bad;
    ifc.FSM_start = 1'b1; ifc.opcode = 4'h0; ifc.param1 = 6'd0; ifc.param2 = 6'd0;
    ifc.immediate = 6'd0; ifc.imm_signed = 1'b0;
    ifc_w.FSM_start = 1'b0; ifc_w.opcode = 4'h0; ifc_w.param1 = 6'd0; ifc_w.param2 = 6'd0;
    ifc_w.immediate = 16'h0; ifc_w.imm_signed = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    cmp_en = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_busy", ifc.busy, 0);
    ifc.FSM_start = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    run_directed(1'b1, 16'hFFFB);
    wait_idle();
    run_directed(1'b0, 16'h003B);
    wait_idle();

    // Abort during LATCH_B, then a normal operation.
    ifc.FSM_start = 1'b1; ifc.immediate = 6'($urandom); ifc.param1 = 6'($urandom);
    ifc.opcode = 4'($urandom); ifc.imm_signed = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ifc.FSM_start = 1'b0;
    repeat (3) @(negedge clock);
    check("lit_latch_b", ifc.latched_bus2_en, 1);
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", ifc.busy, 0);
    check("abort_strobes", {ifc.bus_register_out_en, ifc.latched_bus2_en, ifc.alu_bus_out_en, ifc.done}, 0);
    reset = 1'b1;
    @(negedge clock);
    run_directed(1'b1, 16'hFFFB);
    wait_idle();

    // Start held high for 24 cycles.
    ifc.FSM_start = 1'b1;
    dones = 0; last = -1; gap_bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      ifc.opcode = 4'($urandom); ifc.immediate = 6'($urandom);
      if (ifc.done) begin
        if (last >= 0 && i - last != 8) gap_bad++;
        last = i;
        dones++;
      end
    end
    ifc.FSM_start = 1'b0;
    check("hold_dones", dones, 3);
    check("hold_gap", gap_bad, 0);
    wait_idle();

    // Full-width immediate passes through in either mode.
    for (int s = 0; s < 2; s++) begin
      ifc_w.FSM_start = 1'b1; ifc_w.immediate = 16'h8001; ifc_w.imm_signed = s[0];
      @(posedge clock);
      @(negedge clock);
      ifc_w.FSM_start = 1'b0;
      repeat (2) @(negedge clock);
      check("wide_imm", bus_w, 16'h8001);
      repeat (6) @(negedge clock);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 59) != 0);
      ifc.FSM_start = ($urandom_range(0, 2) == 0);
      ifc.opcode    = 4'($urandom);
      ifc.param1    = 6'($urandom);
      ifc.param2    = 6'($urandom);
      ifc.immediate = 6'($urandom);
      ifc.imm_signed = 1'($urandom);
      @(negedge clock);
    end
    reset = 1'b1;
    ifc.FSM_start = 1'b0;
    @(negedge clock);
    wait_idle();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
